rf_read_arbiter: RTL and testbench
==================================

# rf_read_arbiter

Round-robin arbiter and sequencer for one shared register-file read port: the 32-bit-wide bank of 32:1 bit-select muxes in the ALU library. It accepts read requests from up to NUM_REQ issue slots, drives the 5-bit mux select, and captures the mux output. It returns tagged read data through a two-stage pipeline with valid/ready backpressure. It sits between the superscalar issue stage and the register-file read mux.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_W, 5: register index width (mux select width).
- DATA_W, 32: read data width.
- ID_W, $clog2(NUM_REQ): response tag width.

- clk  input  1  single clock; all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester read request.
- req_addr  input  NUM_REQ*ADDR_W  per-requester register index; slot i at [i*ADDR_W +: ADDR_W].
- req_ready  output  NUM_REQ  one-hot (or zero) accept.
- mux_sel  output  ADDR_W  select to the shared 32:1 mux bank (registered).
- mux_data  input  DATA_W  combinational mux bank output for the current mux_sel.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_W  index of the requester that issued the read.
- rsp_data  output  DATA_W  read data.

## Operation
- Stage S1 (select) holds s1_valid, s1_addr and s1_id. mux_sel = s1_addr.
- Stage S2 (response) holds rsp_valid, rsp_id and rsp_data.
- stall = rsp_valid & ~rsp_ready.
- S2 loads when !stall:
  - rsp_valid <= s1_valid; rsp_id <= s1_id; rsp_data <= mux_data.
  - If S1 is empty, rsp_valid goes 0.
- accept = !s1_valid | !stall.
- S1 loads the granted request when accept. If accept holds and no request is present, s1_valid <= 0.
- s1_addr holds its value when S1 empties, so mux_sel never toggles needlessly.
- Grant selection: round-robin over req_valid, starting at pointer ptr.
  - The first valid index at or after ptr, cyclic, wins.
  - req_ready[i] = grant[i] & accept.
  - req_ready is combinational from req_valid, ptr and the stage state. It does not depend on req_addr.
- ptr update: only on a completed handshake, ptr <= (winner+1) mod NUM_REQ. Otherwise ptr holds.
- Requesters must hold req_valid and req_addr stable until ready. Dropping a request before it is granted is legal and simply removes it from arbitration.
- No requester waits more than NUM_REQ-1 grants while continuously valid.

## Timing
- Reset values: mux_sel=0, rsp_valid=0, rsp_id=0, rsp_data=0, ptr=0, s1_valid=0. req_ready is 0 while all req_valid are 0.
- Latency: a handshake in cycle c gives mux_sel = addr in cycle c+1, and rsp_valid/rsp_data in cycle c+2.
- Throughput: one read per cycle while rsp_ready=1.
- Full: with both stages valid and stall=1, all req_ready are 0, and S1, S2 and mux_sel are frozen.
- When stall clears, S2 takes S1 and S1 takes a new grant in the same cycle.
- Simultaneous requests: only one grant per cycle, and a granted slot cannot be granted again in the next cycle while others are waiting.
- Reset asserted mid-operation: in-flight reads are discarded immediately, all outputs go to reset values, and no response is emitted after release.

## Configuration
- RF_ARB_ZERO_REG_EN defined: a request to address 0 returns rsp_data=0 regardless of mux_data. This is enforced at S2 capture from the s1_addr==0 condition. Latency and mux_sel behave as for any other address.
- Undefined: address 0 returns mux_data like any other index.

## Structure
- Package rf_arb_pkg: ADDR_W/DATA_W defaults, the MAX_REQ=8 constant, and a typedef for the S1 stage record (valid, addr, id).
- Sub-module rr_arbiter: parameter N, with inputs valid[N] and ptr and output one-hot grant[N]. It is purely combinational. The pointer register stays in rf_read_arbiter.

## Test plan
- Reset: assert rst_n=0 mid-stream with both stages valid → rsp_valid=0 and mux_sel=0 in the same cycle; no stray response after release.
- Single read: req_valid=4'b0001, addr=5'd7, mux_data models reg[i]=i*0x11 → mux_sel=7 at c+1; rsp_valid, rsp_id=0, rsp_data=0x77 at c+2.
- Fairness: all four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,…; one response per cycle with rsp_id following that order.
- Backpressure: rsp_ready=0 for 3 cycles with the pipe full → req_ready=0 and outputs stable. Deassert → responses delivered in order with none lost or duplicated.
- Zero register: addr=0 with mux_data=0xDEADBEEF → rsp_data=0 with the macro defined, 0xDEADBEEF without it.
- Pointer wrap: only slots 3 and 0 valid, ptr=3 → grant 3 then 0 then 3.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg
// Shared constants and types for the register-file read arbiter.
//   RF_ADDR_W  : default register index width (select width of the 32:1 mux bank)
//   RF_DATA_W  : default read data width
//   MAX_REQ    : largest supported number of requesters
//   MAX_ID_W   : tag width needed for MAX_REQ requesters
//   MAX_ADDR_W : widest register index the S1 record can hold
//   s1_rec_t   : select-stage record (valid, addr, id)
package rf_arb_pkg;

  localparam int RF_ADDR_W  = 5;
  localparam int RF_DATA_W  = 32;
  localparam int MAX_REQ    = 8;
  localparam int MAX_ID_W   = 3;
  localparam int MAX_ADDR_W = 8;

  // Sized for the largest legal configuration; narrower builds zero-extend
  // into it and truncate back out.
  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_ID_W-1:0]   id;
  } s1_rec_t;

  // Next round-robin start: one past the winner, wrapping at n.
  function automatic int rr_next(input int winner, input int n);
    return (winner >= n - 1) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/rf_read_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: the first asserted valid bit at or
// after ptr (cyclic) wins. The pointer register lives in the parent.
// Ports:
//   valid [N]     : request vector
//   ptr   [PTR_W] : search start index, must be < N
//   grant [N]     : one-hot winner, zero when no request
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [2*N-1:0] valid_dbl;
  logic [N-1:0]   valid_rot;
  logic [N-1:0]   grant_rot;
  logic [2*N-1:0] grant_dbl;
  logic           found;

  // Rotate so that index ptr lands on bit 0; a fixed low-first priority then
  // implements the cyclic search.
  assign valid_dbl = {valid, valid} >> ptr;
  assign valid_rot = valid_dbl[N-1:0];

  always_comb begin
    grant_rot = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && valid_rot[k]) begin
        grant_rot[k] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Rotate the one-hot back; the bit that overflows past N wraps to the bottom.
  assign grant_dbl = {{N{1'b0}}, grant_rot} << ptr;
  assign grant     = grant_dbl[N-1:0] | grant_dbl[2*N-1:N];

endmodule

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter
// Round-robin arbiter and two-stage sequencer for the shared register-file
// read port (32-bit bank of 32:1 bit-select muxes).
//   S1 (select)   : holds the granted address and drives mux_sel.
//   S2 (response) : captures mux_data and presents it with the requester tag.
// Optional feature: define RF_ARB_ZERO_REG_EN to force address 0 reads to
// return zero at S2 capture (mux_sel and latency unchanged).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid [NUM_REQ] : per-slot read request
//   req_addr            : per-slot register index, slot i at [i*ADDR_W +: ADDR_W]
//   req_ready [NUM_REQ] : one-hot (or zero) accept, combinational
//   mux_sel             : registered select to the mux bank
//   mux_data            : combinational mux bank output for mux_sel
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_data    : requester tag and read data
module rf_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         mux_sel,
  input  logic [DATA_W-1:0]         mux_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("rf_read_arbiter: NUM_REQ must be in 2..%0d", MAX_REQ);
  end
  if (ADDR_W > MAX_ADDR_W) begin : g_bad_addr_w
    $error("rf_read_arbiter: ADDR_W exceeds %0d", MAX_ADDR_W);
  end
  if (ID_W > MAX_ID_W) begin : g_bad_id_w
    $error("rf_read_arbiter: ID_W exceeds %0d", MAX_ID_W);
  end

  s1_rec_t            s1;
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant;
  logic               stall;
  logic               accept;
  logic               hs;
  logic [ID_W-1:0]    winner;
  logic [ADDR_W-1:0]  win_addr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [DATA_W-1:0]  s2_data_nxt;

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  assign stall  = rsp_valid & ~rsp_ready;
  // S1 can take a new grant when it is empty or when S2 is about to drain it.
  assign accept = ~s1.valid | ~stall;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = grant & {NUM_REQ{accept}};
  assign hs        = |req_ready;

  // Grant is one-hot, so OR-reducing the selected slots yields the winner's
  // index and address without a priority chain.
  always_comb begin
    winner   = '0;
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        winner   = winner | ID_W'(i);
        win_addr = win_addr | req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign ptr_nxt = ID_W'(rr_next(int'(winner), NUM_REQ));

  // ---------------------------------------------------------------------------
  // S1: select stage and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      ptr <= '0;
    end else if (accept) begin
      s1.valid <= hs;
      if (hs) begin
        s1.addr <= MAX_ADDR_W'(win_addr);
        s1.id   <= MAX_ID_W'(winner);
        ptr     <= ptr_nxt;
      end
      // addr/id deliberately held when S1 empties so mux_sel stays quiet.
    end
  end

  assign mux_sel = ADDR_W'(s1.addr);

  // ---------------------------------------------------------------------------
  // S2: response stage
  // ---------------------------------------------------------------------------
`ifdef RF_ARB_ZERO_REG_EN
  // Register 0 reads as constant zero; decided from the S1 address so the
  // mux bank and its select timing are untouched.
  assign s2_data_nxt = (mux_sel == '0) ? '0 : mux_data;
`else
  assign s2_data_nxt = mux_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (!stall) begin
      rsp_valid <= s1.valid;
      rsp_id    <= ID_W'(s1.id);
      rsp_data  <= s2_data_nxt;
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
module tb_rf_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         mux_sel;
  logic [DATA_W-1:0]         mux_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      zero_mode;

  int errors;
  int checks;

  rf_read_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: reg[i] = i * 0x11, or a poison value for the zero test.
  assign mux_data = zero_mode ? 32'hDEAD_BEEF : (32'(mux_sel) * 32'h11);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic        rr;
    logic [3:0]  exp_ready;
    logic [4:0]  exp_sel;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[30];

  function automatic vec_t mk(input logic [3:0] rv, input logic rr, input logic [3:0] er,
                              input logic [4:0] es, input logic ev, input logic [1:0] ei,
                              input logic [31:0] ed);
    vec_t v;
    v.rv = rv; v.rr = rr; v.exp_ready = er; v.exp_sel = es;
    v.exp_rv = ev; v.exp_id = ei; v.exp_data = ed;
    return v;
  endfunction

  // Slot addresses: 0->7 (0x77), 1->3 (0x33), 2->12 (0xCC), 3->25 (0x1A9)
  initial begin
    //             rv       rr    ready    sel    rv    id     data
    vt[0]  = mk(4'b0000, 1'b1, 4'b0000, 5'd0,  1'b0, 2'd0, 32'h0);
    vt[1]  = mk(4'b0001, 1'b1, 4'b0001, 5'd0,  1'b0, 2'd0, 32'h0);   // single read
    vt[2]  = mk(4'b0000, 1'b1, 4'b0000, 5'd7,  1'b0, 2'd0, 32'h0);
    vt[3]  = mk(4'b0000, 1'b1, 4'b0000, 5'd7,  1'b1, 2'd0, 32'h77);
    vt[4]  = mk(4'b0000, 1'b1, 4'b0000, 5'd7,  1'b0, 2'd0, 32'h0);
    vt[5]  = mk(4'b1111, 1'b1, 4'b0010, 5'd7,  1'b0, 2'd0, 32'h0);   // fairness, ptr=1
    vt[6]  = mk(4'b1111, 1'b1, 4'b0100, 5'd3,  1'b0, 2'd0, 32'h0);
    vt[7]  = mk(4'b1111, 1'b1, 4'b1000, 5'd12, 1'b1, 2'd1, 32'h33);
    vt[8]  = mk(4'b1111, 1'b1, 4'b0001, 5'd25, 1'b1, 2'd2, 32'hCC);
    vt[9]  = mk(4'b1111, 1'b0, 4'b0000, 5'd7,  1'b1, 2'd3, 32'h1A9); // full + stall
    vt[10] = mk(4'b1111, 1'b0, 4'b0000, 5'd7,  1'b1, 2'd3, 32'h1A9);
    vt[11] = mk(4'b1111, 1'b0, 4'b0000, 5'd7,  1'b1, 2'd3, 32'h1A9);
    vt[12] = mk(4'b1111, 1'b1, 4'b0010, 5'd7,  1'b1, 2'd3, 32'h1A9); // release
    vt[13] = mk(4'b0000, 1'b1, 4'b0000, 5'd3,  1'b1, 2'd0, 32'h77);
    vt[14] = mk(4'b0000, 1'b1, 4'b0000, 5'd3,  1'b1, 2'd1, 32'h33);
    vt[15] = mk(4'b0000, 1'b1, 4'b0000, 5'd3,  1'b0, 2'd0, 32'h0);
    vt[16] = mk(4'b0100, 1'b1, 4'b0100, 5'd3,  1'b0, 2'd0, 32'h0);   // move ptr to 3
    vt[17] = mk(4'b1001, 1'b1, 4'b1000, 5'd12, 1'b0, 2'd0, 32'h0);   // wrap: 3,0,3
    vt[18] = mk(4'b1001, 1'b1, 4'b0001, 5'd25, 1'b1, 2'd2, 32'hCC);
    vt[19] = mk(4'b1001, 1'b1, 4'b1000, 5'd7,  1'b1, 2'd3, 32'h1A9);
    vt[20] = mk(4'b0000, 1'b1, 4'b0000, 5'd25, 1'b1, 2'd0, 32'h77);
    vt[21] = mk(4'b0000, 1'b1, 4'b0000, 5'd25, 1'b1, 2'd3, 32'h1A9);
    vt[22] = mk(4'b0000, 1'b1, 4'b0000, 5'd25, 1'b0, 2'd0, 32'h0);
    vt[23] = mk(4'b0001, 1'b0, 4'b0001, 5'd25, 1'b0, 2'd0, 32'h0);   // S1 fills under stall
    vt[24] = mk(4'b0000, 1'b0, 4'b0000, 5'd7,  1'b0, 2'd0, 32'h0);
    vt[25] = mk(4'b0010, 1'b0, 4'b0010, 5'd7,  1'b1, 2'd0, 32'h77);
    vt[26] = mk(4'b0000, 1'b0, 4'b0000, 5'd3,  1'b1, 2'd0, 32'h77);
    vt[27] = mk(4'b0000, 1'b1, 4'b0000, 5'd3,  1'b1, 2'd0, 32'h77);
    vt[28] = mk(4'b0000, 1'b1, 4'b0000, 5'd3,  1'b1, 2'd1, 32'h33);
    vt[29] = mk(4'b0000, 1'b1, 4'b0000, 5'd3,  1'b0, 2'd0, 32'h0);
  end

  initial begin
    logic [31:0] zero_exp;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = {5'd25, 5'd12, 5'd3, 5'd7};
    rsp_ready = 1'b1;
    zero_mode = 1'b0;

    #2;
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset mux_sel",   32'(mux_sel),   32'h0);
    chk("reset rsp_id",    32'(rsp_id),    32'h0);
    chk("reset rsp_data",  rsp_data,       32'h0);
    chk("reset req_ready", 32'(req_ready), 32'h0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      req_valid = vt[k].rv;
      rsp_ready = vt[k].rr;
      #1;
      chk($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(vt[k].exp_ready));
      chk($sformatf("v%0d mux_sel", k),   32'(mux_sel),   32'(vt[k].exp_sel));
      chk($sformatf("v%0d rsp_valid", k), 32'(rsp_valid), 32'(vt[k].exp_rv));
      if (vt[k].exp_rv) begin
        chk($sformatf("v%0d rsp_id", k),   32'(rsp_id), 32'(vt[k].exp_id));
        chk($sformatf("v%0d rsp_data", k), rsp_data,    vt[k].exp_data);
      end
    end

    // Reset mid-stream with both stages full and stalled.
    @(negedge clk);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("prefill rsp_valid", 32'(rsp_valid), 32'h1);
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst mux_sel",   32'(mux_sel),   32'h0);
    chk("midrst rsp_data",  rsp_data,       32'h0);
    chk("midrst req_ready", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst%0d rsp_valid", k), 32'(rsp_valid), 32'h0);
      chk($sformatf("postrst%0d mux_sel", k),   32'(mux_sel),   32'h0);
    end

    // Zero register: slot 0 reads address 0 while the bank returns poison.
`ifdef RF_ARB_ZERO_REG_EN
    zero_exp = 32'h0;
`else
    zero_exp = 32'hDEAD_BEEF;
`endif
    @(negedge clk);
    zero_mode = 1'b1;
    req_addr  = {5'd25, 5'd12, 5'd3, 5'd0};
    req_valid = 4'b0001;
    #1;
    chk("zero req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("zero mux_sel", 32'(mux_sel), 32'h0);
    chk("zero rsp_valid early", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("zero rsp_valid", 32'(rsp_valid), 32'h1);
    chk("zero rsp_id",    32'(rsp_id),    32'h0);
    chk("zero rsp_data",  rsp_data,       zero_exp);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
